uart_add_sequencer: RTL

- Controller that sequences the UART add-and-reply datapath with no push-button involvement.
- Pops two received bytes from the UART RX FIFO as operands A and B, computes their 8-bit sum with carry, and pushes the result into the UART TX FIFO.
- Sits between uart_top (read_uart/write_uart/read_data/write_data) and the display path; it replaces the debounced-button read/write strobe.

---
 rtl/uart_seq_pkg.sv | 20 ++
 rtl/seq_timeout_counter.sv | 28 ++
 rtl/uart_add_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART add-and-reply sequencer.
// Optional carry reply byte is enabled by SEQ_CARRY_BYTE_EN.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_B,
    S_SUM,
    S_TX_SUM,
    S_TX_CARRY
  } seq_state_t;

  localparam int SEQ_DATA_WIDTH     = 8;
  localparam int SEQ_TIMEOUT_CYCLES = 100_000_000;
  localparam int SEQ_TO_CNT_W       = 27;

  localparam logic [7:0] CARRY_BYTE_0 = 8'h00;
  localparam logic [7:0] CARRY_BYTE_1 = 8'h01;

endpackage

// File: rtl/seq_timeout_counter.sv
// Clearable idle-cycle counter with a terminal-count flag,
// usable as a generic UART watchdog.
module seq_timeout_counter #(
  parameter int CNT_W    = 27,
  parameter int TERMINAL = 100_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/uart_add_sequencer.sv
// Pops two RX bytes, adds them, pushes the sum to the TX FIFO.
// Define SEQ_CARRY_BYTE_EN to also push a carry byte per pair.
module uart_add_sequencer
  import uart_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = SEQ_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_CYCLES,
  parameter int TO_CNT_W       = SEQ_TO_CNT_W
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  rx_empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_uart,
  input  logic                  tx_full,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_uart,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  timeout_err
);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_carry;
  logic                  r_valid;
  logic                  w_cnt_clr;
  logic                  w_cnt_en;
  logic                  w_tc;

  seq_timeout_counter #(
    .CNT_W    (TO_CNT_W),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_to (
    .i_clk    (clk_100MHz),
    .i_rst_n  (reset),
    .i_clear  (w_cnt_clr),
    .i_enable (w_cnt_en),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    read_uart   = 1'b0;
    write_uart  = 1'b0;
    timeout_err = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    write_data  = r_result;
    unique case (r_state)
      S_IDLE: begin
        if (!rx_empty) begin
          read_uart = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = S_WAIT_B;
        end
      end
      // A byte in the expiry cycle takes priority over the timeout
      S_WAIT_B: begin
        if (!rx_empty) begin
          read_uart = 1'b1;
          w_next    = S_SUM;
        end else if (w_tc) begin
          timeout_err = 1'b1;
          w_next      = S_IDLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      S_SUM: begin
        w_next = S_TX_SUM;
      end
      S_TX_SUM: begin
        if (!tx_full) begin
          write_uart = 1'b1;
`ifdef SEQ_CARRY_BYTE_EN
          w_next     = S_TX_CARRY;
`else
          w_next     = S_IDLE;
`endif
        end
      end
`ifdef SEQ_CARRY_BYTE_EN
      S_TX_CARRY: begin
        write_data = r_carry ? DATA_WIDTH'(CARRY_BYTE_1)
                             : DATA_WIDTH'(CARRY_BYTE_0);
        if (!tx_full) begin
          write_uart = 1'b1;
          w_next     = S_IDLE;
        end
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (read_uart && (r_state == S_IDLE)) begin
        r_op_a <= read_data;
      end
      if (read_uart && (r_state == S_WAIT_B)) begin
        r_op_b <= read_data;
      end
      if (r_state == S_SUM) begin
        {r_carry, r_result} <= {1'b0, r_op_a} + {1'b0, r_op_b};
      end
      r_valid <= (r_state == S_SUM);
    end
  end

  assign operand_a    = r_op_a;
  assign operand_b    = r_op_b;
  assign result       = r_result;
  assign carry        = r_carry;
  assign result_valid = r_valid;
  assign busy         = (r_state != S_IDLE);

endmodule
